// File: rtl/acq_sram_arbiter.sv
// Single-port acquisition SRAM sequencer. DiscReader bytes (via a one-deep hold
// register) take priority over host read/write requests; each port has its own pointer.
module acq_sram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned WR_CYCLES  = 2
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  acq_wr_i,
    input  logic [7:0]            acq_data_i,
    input  logic                  acq_clr_i,
    input  logic                  host_addr_ld_i,
    input  logic [ADDR_WIDTH-1:0] host_addr_i,
    input  logic                  host_rd_i,
    input  logic                  host_wr_i,
    input  logic [7:0]            host_wdata_i,
    output logic [7:0]            host_rdata_o,
    output logic                  host_rdy_o,
    output logic                  host_busy_o,
    output logic [ADDR_WIDTH-1:0] acq_ptr_o,
    output logic                  ram_full_o,
    output logic                  acq_overrun_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [7:0]            sram_dq_out_o,
    output logic                  sram_dq_oe_o,
    input  logic [7:0]            sram_dq_in_i,
    output logic                  sram_we_n_o,
    output logic                  sram_oe_n_o
);

    localparam int unsigned CNT_W = $clog2(WR_CYCLES + 2);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACQ_WR  = 3'd1,
        HOST_WR = 3'd2,
        HOST_RD = 3'd3,
        RECOVER = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    acq_pend_q, acq_pend_d;
    logic [7:0]              acq_byte_q, acq_byte_d;
    logic                    acq_cancel_q, acq_cancel_d;
    logic [ADDR_WIDTH-1:0]   acq_ptr_q, acq_ptr_d;
    logic                    ram_full_q, ram_full_d;
    logic                    overrun_q, overrun_d;
    logic                    host_pend_q, host_pend_d;
    logic                    host_dir_wr_q, host_dir_wr_d;
    logic [7:0]              host_byte_q, host_byte_d;
    logic [ADDR_WIDTH-1:0]   host_ptr_q, host_ptr_d;
    logic                    host_busy_q, host_busy_d;
    logic                    host_rdy_q, host_rdy_d;
    logic [7:0]              host_rdata_q, host_rdata_d;
    logic [ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
    logic [7:0]              sram_dq_q, sram_dq_d;
    logic                    dq_oe_q, dq_oe_d;
    logic                    we_n_q, we_n_d;
    logic                    oe_n_q, oe_n_d;
    logic                    acq_consume;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acq_pend_d    = acq_pend_q;
        acq_byte_d    = acq_byte_q;
        acq_cancel_d  = acq_cancel_q;
        acq_ptr_d     = acq_ptr_q;
        ram_full_d    = ram_full_q;
        overrun_d     = overrun_q;
        host_pend_d   = host_pend_q;
        host_dir_wr_d = host_dir_wr_q;
        host_byte_d   = host_byte_q;
        host_ptr_d    = host_ptr_q;
        host_busy_d   = host_busy_q;
        host_rdy_d    = 1'b0;
        host_rdata_d  = host_rdata_q;
        sram_addr_d   = sram_addr_q;
        sram_dq_d     = sram_dq_q;
        dq_oe_d       = dq_oe_q;
        we_n_d        = we_n_q;
        oe_n_d        = oe_n_q;
        acq_consume   = 1'b0;

        // SRAM sequencer; outputs are registered alongside the state they belong to
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (acq_pend_q && !ram_full_q && !acq_clr_i) begin
                    acq_consume  = 1'b1;
                    acq_cancel_d = 1'b0;
                    state_d      = ACQ_WR;
                    sram_addr_d  = acq_ptr_q;
                    sram_dq_d    = acq_byte_q;
                    dq_oe_d      = 1'b1;
                    we_n_d       = 1'b0;
                end else if (host_pend_q) begin
                    host_pend_d = 1'b0;
                    sram_addr_d = host_ptr_q;
                    if (host_dir_wr_q) begin
                        state_d   = HOST_WR;
                        sram_dq_d = host_byte_q;
                        dq_oe_d   = 1'b1;
                        we_n_d    = 1'b0;
                    end else begin
                        state_d = HOST_RD;
                        oe_n_d  = 1'b0;
                    end
                end
            end
            ACQ_WR, HOST_WR: begin
                if (cnt_q == WR_LAST) begin
                    state_d = RECOVER;
                    cnt_d   = '0;
                    we_n_d  = 1'b1;
                    if (state_q == ACQ_WR) begin
                        if (!acq_cancel_q && !acq_clr_i) begin
                            acq_ptr_d = acq_ptr_q + ADDR_WIDTH'(1);
                            if (acq_ptr_q == ADDR_LAST) begin
                                ram_full_d = 1'b1;
                            end
                        end
                    end else begin
                        host_ptr_d  = host_ptr_q + ADDR_WIDTH'(1);
                        host_rdy_d  = 1'b1;
                        host_busy_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOST_RD: begin
                if (cnt_q == RD_LAST) begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    oe_n_d       = 1'b1;
                    host_rdata_d = sram_dq_in_i;
                    host_ptr_d   = host_ptr_q + ADDR_WIDTH'(1);
                    host_rdy_d   = 1'b1;
                    host_busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RECOVER: begin
                state_d = IDLE;
                dq_oe_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                we_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                dq_oe_d = 1'b0;
            end
        endcase

        // Hold register: a byte that would land in a full RAM is dropped as overrun
        if (acq_consume) begin
            acq_pend_d = 1'b0;
        end
        if (acq_pend_q && ram_full_q) begin
            acq_pend_d = 1'b0;
            overrun_d  = 1'b1;
        end
        if (acq_wr_i) begin
            if (ram_full_q || (acq_pend_q && !acq_consume)) begin
                overrun_d = 1'b1;
            end else begin
                acq_pend_d = 1'b1;
                acq_byte_d = acq_data_i;
            end
        end
        if (acq_clr_i) begin
            acq_ptr_d  = '0;
            ram_full_d = 1'b0;
            overrun_d  = 1'b0;
            acq_pend_d = 1'b0;
            if (state_q == ACQ_WR) begin
                acq_cancel_d = 1'b1;
            end
        end

        // Host request capture; pointer load and strobes are ignored while busy
        if (!host_busy_q) begin
            if (host_addr_ld_i) begin
                host_ptr_d = host_addr_i;
            end
            if (host_wr_i || host_rd_i) begin
                host_pend_d   = 1'b1;
                host_busy_d   = 1'b1;
                host_dir_wr_d = host_wr_i;
                host_byte_d   = host_wdata_i;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            acq_pend_q    <= 1'b0;
            acq_byte_q    <= '0;
            acq_cancel_q  <= 1'b0;
            acq_ptr_q     <= '0;
            ram_full_q    <= 1'b0;
            overrun_q     <= 1'b0;
            host_pend_q   <= 1'b0;
            host_dir_wr_q <= 1'b0;
            host_byte_q   <= '0;
            host_ptr_q    <= '0;
            host_busy_q   <= 1'b0;
            host_rdy_q    <= 1'b0;
            host_rdata_q  <= '0;
            sram_addr_q   <= '0;
            sram_dq_q     <= '0;
            dq_oe_q       <= 1'b0;
            we_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acq_pend_q    <= acq_pend_d;
            acq_byte_q    <= acq_byte_d;
            acq_cancel_q  <= acq_cancel_d;
            acq_ptr_q     <= acq_ptr_d;
            ram_full_q    <= ram_full_d;
            overrun_q     <= overrun_d;
            host_pend_q   <= host_pend_d;
            host_dir_wr_q <= host_dir_wr_d;
            host_byte_q   <= host_byte_d;
            host_ptr_q    <= host_ptr_d;
            host_busy_q   <= host_busy_d;
            host_rdy_q    <= host_rdy_d;
            host_rdata_q  <= host_rdata_d;
            sram_addr_q   <= sram_addr_d;
            sram_dq_q     <= sram_dq_d;
            dq_oe_q       <= dq_oe_d;
            we_n_q        <= we_n_d;
            oe_n_q        <= oe_n_d;
        end
    end

    assign host_rdata_o  = host_rdata_q;
    assign host_rdy_o    = host_rdy_q;
    assign host_busy_o   = host_busy_q;
    assign acq_ptr_o     = acq_ptr_q;
    assign ram_full_o    = ram_full_q;
    assign acq_overrun_o = overrun_q;
    assign sram_addr_o   = sram_addr_q;
    assign sram_dq_out_o = sram_dq_q;
    assign sram_dq_oe_o  = dq_oe_q;
    assign sram_we_n_o   = we_n_q;
    assign sram_oe_n_o   = oe_n_q;

endmodule

// File: tb/tb_acq_sram_arbiter.sv
// Bench for acq_sram_arbiter: directed scenarios followed by a randomized run
// checked against an array/pointer model of the acquisition RAM.
module tb_acq_sram_arbiter;

    localparam int unsigned AW    = 3;
    localparam int unsigned WRC   = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          acq_wr;
    logic [7:0]    acq_data;
    logic          acq_clr;
    logic          host_addr_ld;
    logic [AW-1:0] host_addr;
    logic          host_rd;
    logic          host_wr;
    logic [7:0]    host_wdata;
    logic [7:0]    host_rdata;
    logic          host_rdy;
    logic          host_busy;
    logic [AW-1:0] acq_ptr;
    logic          ram_full;
    logic          acq_overrun;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_dq_out;
    logic          sram_dq_oe;
    logic [7:0]    sram_dq_in;
    logic          sram_we_n;
    logic          sram_oe_n;

    logic [7:0]    sram [DEPTH];
    logic          sram_clear;
    logic          preload_en;
    logic [AW-1:0] preload_addr;
    logic [7:0]    preload_val;

    int checks = 0;
    int passed = 0;
    int we_low_len = 0;
    int we_pulses = 0;

    always #5 clk = ~clk;

    acq_sram_arbiter #(.ADDR_WIDTH(AW), .WR_CYCLES(WRC)) dut (
        .clock_i        (clk),
        .reset_ni       (rst_n),
        .acq_wr_i       (acq_wr),
        .acq_data_i     (acq_data),
        .acq_clr_i      (acq_clr),
        .host_addr_ld_i (host_addr_ld),
        .host_addr_i    (host_addr),
        .host_rd_i      (host_rd),
        .host_wr_i      (host_wr),
        .host_wdata_i   (host_wdata),
        .host_rdata_o   (host_rdata),
        .host_rdy_o     (host_rdy),
        .host_busy_o    (host_busy),
        .acq_ptr_o      (acq_ptr),
        .ram_full_o     (ram_full),
        .acq_overrun_o  (acq_overrun),
        .sram_addr_o    (sram_addr),
        .sram_dq_out_o  (sram_dq_out),
        .sram_dq_oe_o   (sram_dq_oe),
        .sram_dq_in_i   (sram_dq_in),
        .sram_we_n_o    (sram_we_n),
        .sram_oe_n_o    (sram_oe_n)
    );

    // Behavioural asynchronous SRAM (write sampled each clock while we_n is low)
    always @(posedge clk) begin
        if (sram_clear) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= 8'h00;
        end else if (preload_en) begin
            sram[preload_addr] <= preload_val;
        end else if (!sram_we_n) begin
            sram[sram_addr] <= sram_dq_out;
        end
    end
    assign sram_dq_in = sram_oe_n ? 8'h00 : sram[sram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Bus invariants and write-pulse width, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            we_low_len = 0;
        end else begin
            check("we_oe_both_low", 32'(!sram_we_n && !sram_oe_n), 32'd0);
            check("dq_oe_during_read", 32'(sram_dq_oe && !sram_oe_n), 32'd0);
            if (!sram_we_n) begin
                we_low_len++;
            end else if (we_low_len != 0) begin
                check("we_pulse_width", 32'(we_low_len), 32'(WRC));
                we_pulses++;
                we_low_len = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic acq_strobe(input logic [7:0] d);
        acq_wr = 1'b1;
        acq_data = d;
        tick(1);
        acq_wr = 1'b0;
    endtask

    task automatic pulse_clr();
        acq_clr = 1'b1;
        tick(1);
        acq_clr = 1'b0;
    endtask

    task automatic clear_sram();
        sram_clear = 1'b1;
        tick(1);
        sram_clear = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] v);
        preload_en = 1'b1;
        preload_addr = a;
        preload_val = v;
        tick(1);
        preload_en = 1'b0;
    endtask

    // Returns clocks from strobe to host_rdy (1 = first clock after the strobe edge)
    task automatic wait_rdy(input string tag, output int lat);
        lat = 1;
        while (!host_rdy && lat < 40) begin
            tick(1);
            lat++;
        end
        check(tag, 32'(host_rdy), 32'd1);
    endtask

    task automatic host_req(input logic ld, input logic [AW-1:0] a, input logic rd,
                            input logic wr, input logic [7:0] d);
        host_addr_ld = ld;
        host_addr = a;
        host_rd = rd;
        host_wr = wr;
        host_wdata = d;
        tick(1);
        host_addr_ld = 1'b0;
        host_rd = 1'b0;
        host_wr = 1'b0;
    endtask

    logic [7:0] fill [DEPTH];
    logic [7:0] exp_mem [DEPTH];
    int m_ptr, m_hptr, lat, w0;
    logic m_full, m_ovr, ld;
    logic [7:0] d;
    logic [AW-1:0] a;

    initial begin
        rst_n = 1'b0;
        acq_wr = 1'b0; acq_data = '0; acq_clr = 1'b0;
        host_addr_ld = 1'b0; host_addr = '0; host_rd = 1'b0; host_wr = 1'b0; host_wdata = '0;
        sram_clear = 1'b1; preload_en = 1'b0; preload_addr = '0; preload_val = '0;
        tick(2);
        sram_clear = 1'b0;

        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_acq_ptr", 32'(acq_ptr), 32'd0);
        check("rst_busy", 32'(host_busy), 32'd0);
        check("rst_rdata", 32'(host_rdata), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Reset in the middle of an acquisition write
        acq_strobe(8'hEE);
        check("acq_lat_c1_we_n", 32'(sram_we_n), 32'd1);
        tick(1);
        check("acq_lat_c2_we_n", 32'(sram_we_n), 32'd0);
        check("acq_wr_dq", 32'(sram_dq_out), 32'hEE);
        check("acq_wr_dq_oe", 32'(sram_dq_oe), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_we_n", 32'(sram_we_n), 32'd1);
        check("async_rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("async_rst_ptr", 32'(acq_ptr), 32'd0);
        check("async_rst_flags", 32'({ram_full, acq_overrun}), 32'd0);
        sram_clear = 1'b1;
        tick(1);
        sram_clear = 1'b0;
        rst_n = 1'b1;
        tick(2);

        // Two spaced acquisition bytes
        w0 = we_pulses;
        acq_strobe(8'hA5);
        tick(5);
        acq_strobe(8'h5A);
        tick(8);
        check("sram0_a5", 32'(sram[0]), 32'hA5);
        check("sram1_5a", 32'(sram[1]), 32'h5A);
        check("ptr_after_two", 32'(acq_ptr), 32'd2);
        check("no_overrun", 32'(acq_overrun), 32'd0);
        check("two_write_pulses", 32'(we_pulses - w0), 32'd2);

        // Back-to-back bytes during a write: the first is held, the second dropped
        acq_strobe(8'h11);
        tick(1);
        acq_strobe(8'h22);
        acq_strobe(8'h33);
        tick(12);
        check("sram2_11", 32'(sram[2]), 32'h11);
        check("sram3_22", 32'(sram[3]), 32'h22);
        check("sram4_untouched", 32'(sram[4]), 32'h00);
        check("ptr_after_drop", 32'(acq_ptr), 32'd4);
        check("overrun_set", 32'(acq_overrun), 32'd1);

        // Fill to the last address, then overflow
        pulse_clr();
        check("clr_ptr", 32'(acq_ptr), 32'd0);
        check("clr_overrun", 32'(acq_overrun), 32'd0);
        clear_sram();
        for (int i = 0; i < DEPTH; i++) begin
            fill[i] = 8'($urandom);
            if (i == DEPTH - 1) check("full_before_last", 32'(ram_full), 32'd0);
            acq_strobe(fill[i]);
            tick(5);
        end
        check("full_after_fill", 32'(ram_full), 32'd1);
        check("ptr_wrapped", 32'(acq_ptr), 32'd0);
        for (int i = 0; i < DEPTH; i++) check("fill_data", 32'(sram[i]), 32'(fill[i]));
        acq_strobe(~fill[0]);
        tick(6);
        check("overrun_when_full", 32'(acq_overrun), 32'd1);
        check("sram0_kept", 32'(sram[0]), 32'(fill[0]));
        pulse_clr();
        check("clr_flags", 32'({ram_full, acq_overrun}), 32'd0);
        check("clr_ptr2", 32'(acq_ptr), 32'd0);

        // Host read latency and pointer increment
        preload(AW'(3), 8'h3C);
        host_req(1'b1, AW'(3), 1'b1, 1'b0, 8'h00);
        check("hrd_busy_c1", 32'(host_busy), 32'd1);
        check("hrd_rdy_c1", 32'(host_rdy), 32'd0);
        tick(1);
        check("hrd_oe_c2", 32'(sram_oe_n), 32'd0);
        check("hrd_addr", 32'(sram_addr), 32'd3);
        tick(1);
        check("hrd_rdy_c3", 32'(host_rdy), 32'd0);
        tick(1);
        check("hrd_rdy_c4", 32'(host_rdy), 32'd1);
        check("hrd_busy_c4", 32'(host_busy), 32'd0);
        check("hrd_data", 32'(host_rdata), 32'h3C);
        tick(1);
        check("hrd_rdy_pulse", 32'(host_rdy), 32'd0);
        host_req(1'b0, '0, 1'b0, 1'b1, 8'h77);
        wait_rdy("hwr_timeout", lat);
        tick(2);
        check("hwr_sram4", 32'(sram[4]), 32'h77);

        // Simultaneous host read and acquisition byte: acquisition goes first
        preload(AW'(5), 8'h5C);
        acq_wr = 1'b1; acq_data = 8'h99; host_rd = 1'b1;
        tick(1);
        acq_wr = 1'b0; host_rd = 1'b0;
        wait_rdy("mix_timeout", lat);
        check("mix_latency", 32'(lat), 32'(4 + WRC + 2));
        check("mix_rdata", 32'(host_rdata), 32'h5C);
        tick(2);
        check("mix_acq_sram0", 32'(sram[0]), 32'h99);
        check("mix_acq_ptr", 32'(acq_ptr), 32'd1);

        // Clear during a write: cycle completes, pointer stays cleared
        acq_strobe(8'hD7);
        tick(1);
        acq_clr = 1'b1;
        tick(1);
        acq_clr = 1'b0;
        tick(6);
        check("clr_mid_sram1", 32'(sram[1]), 32'hD7);
        check("clr_mid_ptr", 32'(acq_ptr), 32'd0);
        w0 = we_pulses;
        acq_wr = 1'b1; acq_data = 8'hE1; acq_clr = 1'b1;
        tick(1);
        acq_wr = 1'b0; acq_clr = 1'b0;
        tick(8);
        check("clr_beats_wr_ptr", 32'(acq_ptr), 32'd0);
        check("clr_beats_wr_ovr", 32'(acq_overrun), 32'd0);
        check("clr_beats_wr_nowrite", 32'(we_pulses - w0), 32'd0);

        // Write beats read; strobes and pointer loads while busy are ignored
        host_req(1'b1, AW'(6), 1'b1, 1'b1, 8'h6B);
        wait_rdy("rdwr_timeout", lat);
        tick(2);
        check("write_wins", 32'(sram[6]), 32'h6B);
        host_req(1'b1, AW'(6), 1'b1, 1'b0, 8'h00);
        host_req(1'b1, AW'(2), 1'b0, 1'b1, ~fill[2]);
        wait_rdy("busy_timeout", lat);
        check("busy_rd_data", 32'(host_rdata), 32'h6B);
        tick(2);
        check("busy_wr_ignored", 32'(sram[2]), 32'(fill[2]));
        host_req(1'b0, '0, 1'b1, 1'b0, 8'h00);
        wait_rdy("ld_ignored_timeout", lat);
        check("ld_ignored_ptr7", 32'(host_rdata), 32'(fill[7]));
        tick(2);

        // Randomized mix against the array model; host pointer has wrapped to 0
        pulse_clr();
        clear_sram();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'h00;
        m_ptr = 0; m_hptr = 0; m_full = 1'b0; m_ovr = 1'b0;
        for (int it = 0; it < 40; it++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                acq_strobe(d);
                if (m_full) m_ovr = 1'b1;
                else begin
                    exp_mem[m_ptr] = d;
                    m_ptr = (m_ptr + 1) % DEPTH;
                    if (m_ptr == 0) m_full = 1'b1;
                end
                tick(6);
                check("rnd_acq_ptr", 32'(acq_ptr), 32'(m_ptr));
                check("rnd_full", 32'(ram_full), 32'(m_full));
                check("rnd_ovr", 32'(acq_overrun), 32'(m_ovr));
            end else begin
                ld = 1'($urandom);
                a = AW'($urandom);
                if (ld) m_hptr = int'(a);
                if ($urandom_range(0, 1) == 0) begin
                    host_req(ld, a, 1'b1, 1'b0, 8'h00);
                    wait_rdy("rnd_rd_timeout", lat);
                    check("rnd_rdata", 32'(host_rdata), 32'(exp_mem[m_hptr]));
                end else begin
                    host_req(ld, a, 1'b0, 1'b1, d);
                    wait_rdy("rnd_wr_timeout", lat);
                    exp_mem[m_hptr] = d;
                end
                m_hptr = (m_hptr + 1) % DEPTH;
                tick(2);
            end
        end
        for (int i = 0; i < DEPTH; i++) check("rnd_final_mem", 32'(sram[i]), 32'(exp_mem[i]));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
